// File: rtl/layer_argmax_classifier.sv
// Running argmax over one frame of output-layer node results.
// Optional ARGMAX_MARGIN_EN adds second-best tracking and out_margin.
module layer_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_digit,
`ifdef ARGMAX_MARGIN_EN
  output logic [DATA_W-1:0] out_margin,
`endif
  output logic [DATA_W-1:0] out_score
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_HOLD
  } state_e;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_CLASSES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  digit_q, digit_d;
  logic [DATA_W-1:0] score_q, score_d;

  logic              accept;
  logic              clr;
  logic [DATA_W-1:0] nb_best;
  logic [IDX_W-1:0]  nb_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic [DATA_W-1:0] MOST_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] sec_q, sec_d;
  logic [DATA_W-1:0] margin_q, margin_d;
  logic [DATA_W-1:0] nb_sec;
  logic [DATA_W:0]   diff;
`endif

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_HOLD);
  assign out_digit = digit_q;
  assign out_score = score_q;
`ifdef ARGMAX_MARGIN_EN
  assign out_margin = margin_q;
`endif

  // Candidate best/idx after folding in the current beat.
  always_comb begin
    nb_best = best_q;
    nb_idx  = idx_q;
`ifdef ARGMAX_MARGIN_EN
    nb_sec  = sec_q;
`endif
    if (cnt_q == '0) begin
      nb_best = in_data;
      nb_idx  = '0;
`ifdef ARGMAX_MARGIN_EN
      nb_sec  = MOST_NEG;
`endif
    end else if ($signed(in_data) > $signed(best_q)) begin
      nb_best = in_data;
      nb_idx  = cnt_q;
`ifdef ARGMAX_MARGIN_EN
      nb_sec  = best_q;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if ($signed(in_data) > $signed(sec_q)) begin
      nb_sec = in_data;
    end
    diff = {nb_best[DATA_W-1], nb_best}
         - {nb_sec[DATA_W-1], nb_sec};
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    best_d   = best_q;
    idx_d    = idx_q;
    digit_d  = digit_q;
    score_d  = score_q;
`ifdef ARGMAX_MARGIN_EN
    sec_d    = sec_q;
    margin_d = margin_q;
`endif
    clr      = 1'b0;
    accept   = in_valid && (state_q == S_COLLECT);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          clr     = 1'b1;
        end
      end
      S_COLLECT: begin
        // A restart wins over any beat presented alongside it.
        if (start) begin
          clr = 1'b1;
        end else if (accept) begin
          best_d = nb_best;
          idx_d  = nb_idx;
`ifdef ARGMAX_MARGIN_EN
          sec_d  = nb_sec;
`endif
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_HOLD;
            digit_d = nb_idx;
            score_d = nb_best;
`ifdef ARGMAX_MARGIN_EN
            margin_d = diff[DATA_W] ? '1
                                    : diff[DATA_W-1:0];
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d = S_COLLECT;
            clr     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      cnt_d  = '0;
      best_d = '0;
      idx_d  = '0;
`ifdef ARGMAX_MARGIN_EN
      sec_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      best_q   <= '0;
      idx_q    <= '0;
      digit_q  <= '0;
      score_q  <= '0;
`ifdef ARGMAX_MARGIN_EN
      sec_q    <= '0;
      margin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      best_q   <= best_d;
      idx_q    <= idx_d;
      digit_q  <= digit_d;
      score_q  <= score_d;
`ifdef ARGMAX_MARGIN_EN
      sec_q    <= sec_d;
      margin_q <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_layer_argmax_classifier.sv
// Directed bench for layer_argmax_classifier.
// Frame table plus hand sequences for handshake, abort and reset.
module tb_layer_argmax_classifier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_digit;
  logic [31:0] out_score;
`ifdef ARGMAX_MARGIN_EN
  logic [31:0] out_margin;
`endif

  layer_argmax_classifier #(
    .NUM_CLASSES(10),
    .DATA_W(32),
    .IDX_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
`ifdef ARGMAX_MARGIN_EN
    .out_margin(out_margin),
`endif
    .out_score(out_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d[10];
    logic [3:0]  dig;
    logic [31:0] score;
    logic [31:0] margin;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  int n_checks;
  int n_fail;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int vi, input bit gaps,
                      input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = vecs[vi].d[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called one cycle after the last beat was accepted.
  task automatic check_result(input string name,
                              input int vi);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".rdy"}, 64'(in_ready), 64'd0);
    chk({name, ".digit"}, 64'(out_digit),
        64'(vecs[vi].dig));
    chk({name, ".score"}, 64'(out_score),
        64'(vecs[vi].score));
`ifdef ARGMAX_MARGIN_EN
    chk({name, ".margin"}, 64'(out_margin),
        64'(vecs[vi].margin));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0].d = '{3, 7, 1, 9, 0, 2, 4, 8, 5, 6};
    vecs[0].dig = 4'd3;
    vecs[0].score = 32'd9;
    vecs[0].margin = 32'd1;
    vecs[1].d = '{-5, -2, -2, -9, -10, -10, -10,
                  -10, -10, -10};
    vecs[1].dig = 4'd1;
    vecs[1].score = 32'hFFFF_FFFE;
    vecs[1].margin = 32'd0;
    vecs[2].d = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    vecs[2].dig = 4'd9;
    vecs[2].score = 32'd9;
    vecs[2].margin = 32'd1;
    vecs[3].d = '{100, 50, 100, 7, 7, 7, 7, 7, 7, 7};
    vecs[3].dig = 4'd0;
    vecs[3].score = 32'd100;
    vecs[3].margin = 32'd0;
    vecs[4].d = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
    vecs[4].dig = 4'd0;
    vecs[4].score = 32'd42;
    vecs[4].margin = 32'd0;
    vecs[5].d = '{32'h7FFF_FFFF, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000};
    vecs[5].dig = 4'd0;
    vecs[5].score = 32'h7FFF_FFFF;
    vecs[5].margin = 32'hFFFF_FFFF;
    vecs[6].d = '{-1, -8, -3, -20, -2, -7, -4, -5, -6, -9};
    vecs[6].dig = 4'd0;
    vecs[6].score = 32'hFFFF_FFFF;
    vecs[6].margin = 32'd1;

    repeat (2) @(negedge clk);
    chk("rst.rdy", 64'(in_ready), 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.digit", 64'(out_digit), 64'd0);
    chk("rst.score", 64'(out_score), 64'd0);
`ifdef ARGMAX_MARGIN_EN
    chk("rst.margin", 64'(out_margin), 64'd0);
`endif
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd99;
    @(negedge clk);
    chk("idle.rdy", 64'(in_ready), 64'd0);
    chk("idle.valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_pulse();
      chk($sformatf("v%0d.rdy", i), 64'(in_ready), 64'd1);
      feed(i, (i % 2) == 1, 10);
      check_result($sformatf("v%0d", i), i);
    end

    // Backpressure: result held, start in HOLD ignored.
    start_pulse();
    feed(0, 1'b1, 10);
    for (int c = 0; c < 5; c++) begin
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.rdy", 64'(in_ready), 64'd0);
      chk("bp.digit", 64'(out_digit), 64'd3);
      chk("bp.score", 64'(out_score), 64'd9);
      start = (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check_result("bp", 0);
    chk("bp.idle", 64'(in_ready), 64'd0);

    // Abort after 4 large beats; beat alongside start dropped.
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'd50;
      @(negedge clk);
    end
    start   = 1'b1;
    in_data = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    chk("abort.rdy", 64'(in_ready), 64'd1);
    feed(2, 1'b0, 10);
    check_result("abort", 2);

    // Start coincident with HOLD handshake restarts collection.
    start_pulse();
    feed(0, 1'b0, 10);
    chk("hs.valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("hs.drop", 64'(out_valid), 64'd0);
    chk("hs.rdy", 64'(in_ready), 64'd1);
    feed(1, 1'b0, 10);
    check_result("hs", 1);

    // Asynchronous reset mid-frame.
    start_pulse();
    feed(0, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    chk("arst.rdy", 64'(in_ready), 64'd0);
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.digit", 64'(out_digit), 64'd0);
    chk("arst.score", 64'(out_score), 64'd0);
`ifdef ARGMAX_MARGIN_EN
    chk("arst.margin", 64'(out_margin), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    feed(6, 1'b1, 10);
    check_result("post", 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
